dsc_mul_param: RTL

- Parametrised deterministic stochastic-computing (DSC) multiplier of NUM_INPUTS unsigned SNG_WIDTH-bit operands.
- Each operand drives one comparator-based SNG channel. The channels form a single-clock, enable-chained mixed-radix counter: channel k advances only when channels 0..k-1 all wrap. There are no derived clocks.
- The AND of all streams is counted into an exact NUM_INPUTS*SNG_WIDTH-bit product.
- Start/busy/done handshake so it can sit under a controller or bus wrapper.

---
 rtl/dsc_pkg.sv | 24 ++
 rtl/dsc_mul_param_if.sv | 36 +++
 rtl/dsc_sng_cmp.sv | 49 ++++
 rtl/dsc_mul_param.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic-computing multiplier.
// Holds:
//   - default parameter values;
//   - the FSM state type;
//   - a helper that returns the all-ones value of a channel counter.
// Optional feature macro used elsewhere in the slice: DSC_EARLY_SHUTOFF_EN.
package dsc_pkg;

  localparam int DSC_SNG_WIDTH_DEF  = 6;
  localparam int DSC_NUM_INPUTS_DEF = 4;
  localparam int TOTAL_W            = DSC_SNG_WIDTH_DEF * DSC_NUM_INPUTS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dsc_state_e;

  // All-ones value of a w-bit channel counter (its wrap point).
  function automatic logic [31:0] chan_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/dsc_mul_param_if.sv
// Handshake/bus bundle of dsc_mul_param.
// Signals:
//   start - request, sampled only in IDLE
//   en    - run enable (pause when low)
//   ops   - packed operands
//   z     - product accumulator
//   busy  - high while running
//   done  - one-cycle completion pulse
//   valid - z holds a final result
// Modports:
//   master - controller side, drives start/en/ops
//   slave  - multiplier side
interface dsc_mul_param_if
  import dsc_pkg::*;
#(
  parameter int NUM_INPUTS = DSC_NUM_INPUTS_DEF,
  parameter int SNG_WIDTH  = DSC_SNG_WIDTH_DEF
);
  logic                              start;
  logic                              en;
  logic [NUM_INPUTS*SNG_WIDTH-1:0]   ops;
  logic [NUM_INPUTS*SNG_WIDTH-1:0]   z;
  logic                              busy;
  logic                              done;
  logic                              valid;

  modport master (
    output start, en, ops,
    input  z, busy, done, valid
  );

  modport slave (
    input  start, en, ops,
    output z, busy, done, valid
  );
endinterface

// File: rtl/dsc_sng_cmp.sv
// One comparator-based stochastic number generator channel.
// The counter is one digit of a mixed-radix counter: it advances on a step
// only when every lower channel is at its maximum (i_carry_in).
// Ports:
//   clk         - clock
//   rst         - synchronous active-low reset
//   i_clear     - zero the counter
//   i_step      - a RUN step is taken this cycle
//   i_carry_in  - all lower channels at max (tie to 1 for channel 0)
//   i_op        - latched operand
//   o_sn        - stream bit, counter < operand
//   o_carry_out - i_carry_in & counter at max
//   o_at_last   - counter == operand-1 (used for early termination)
module dsc_sng_cmp
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH = DSC_SNG_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_step,
  input  logic                 i_carry_in,
  input  logic [SNG_WIDTH-1:0] i_op,
  output logic                 o_sn,
  output logic                 o_carry_out,
  output logic                 o_at_last
);

  localparam logic [SNG_WIDTH-1:0] CNT_MAX = SNG_WIDTH'(chan_max(SNG_WIDTH));

  logic [SNG_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_step && i_carry_in) begin
      // natural wrap from max back to zero
      r_cnt <= r_cnt + SNG_WIDTH'(1);
    end
  end

  assign o_sn        = (r_cnt < i_op);
  assign o_carry_out = i_carry_in & (r_cnt == CNT_MAX);
  assign o_at_last   = (r_cnt == (i_op - SNG_WIDTH'(1)));

endmodule

// File: rtl/dsc_mul_param.sv
// Deterministic stochastic-computing multiplier of NUM_INPUTS unsigned
// SNG_WIDTH-bit operands.
// The channel counters form one mixed-radix counter, so every combination of
// channel values is visited exactly once. Counting the cycles where all
// streams are high therefore gives the exact product.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-low reset
//   bus - dsc_mul_param_if.slave (start/en/ops in, z/busy/done/valid out)
// Optional feature: define DSC_EARLY_SHUTOFF_EN to stop as soon as the top
// stream can no longer be high (same result, shorter run).
module dsc_mul_param
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH  = DSC_SNG_WIDTH_DEF,
  parameter int NUM_INPUTS = DSC_NUM_INPUTS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  dsc_mul_param_if.slave        bus
);

  localparam int TW = NUM_INPUTS * SNG_WIDTH;

  dsc_state_e                  r_state;
  logic [TW-1:0]               r_ops;
  logic [TW-1:0]               r_z;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_valid;

  logic [NUM_INPUTS-1:0]       w_sn;
  logic [NUM_INPUTS-1:0]       w_at_last;
  logic [NUM_INPUTS:0]         w_carry;
  logic                        w_clear;
  logic                        w_step;
  logic                        w_prod;
  logic                        w_finish;

  assign w_clear    = (r_state == ST_IDLE) && bus.start;
  assign w_step     = (r_state == ST_RUN) && bus.en;
  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      dsc_sng_cmp #(
        .SNG_WIDTH (SNG_WIDTH)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_step      (w_step),
        .i_carry_in  (w_carry[gi]),
        .i_op        (r_ops[gi*SNG_WIDTH +: SNG_WIDTH]),
        .o_sn        (w_sn[gi]),
        .o_carry_out (w_carry[gi+1]),
        .o_at_last   (w_at_last[gi])
      );
    end
  endgenerate

  assign w_prod = &w_sn;

`ifdef DSC_EARLY_SHUTOFF_EN
  // Lower channels about to wrap while the top counter sits at op-1: the top
  // stream is zero from here on. A zero top operand ends the run at once.
  assign w_finish = w_carry[NUM_INPUTS]
                  | (w_carry[NUM_INPUTS-1] & w_at_last[NUM_INPUTS-1])
                  | (r_ops[(NUM_INPUTS-1)*SNG_WIDTH +: SNG_WIDTH] == '0);
`else
  // Whole counter at max: the last combination is being visited.
  assign w_finish = w_carry[NUM_INPUTS];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ops   <= '0;
      r_z     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_ops   <= bus.ops;
            r_z     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            r_z <= r_z + TW'(w_prod);
            if (w_finish) begin
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.z     = r_z;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.valid = r_valid;

endmodule
